// File: rtl/fifo_read_logic.sv
// ---------------------------------------------------------------------------
// fifo_read_logic
//
// Read-side pointer and flag logic for the small FIFO. It takes the Gray-coded
// write pointer that has already been brought into the read domain. From it
// the block produces the following:
//   - the binary read address and the read strobe for the storage array
//   - the empty flag and the occupancy count
//   - the Gray read pointer that goes back to the write side
//   - registered read data with a one-cycle valid pulse
//
// Pointers count modulo DEPTH, which need not be a power of two. One slot is
// always left unused, so the FIFO is empty exactly when the read pointer
// equals the write pointer.
//
// Handshake: a read is accepted in any cycle where rinc=1, the FIFO is not
// empty, the control FSM has left INIT, and rst=0. read_en is high in exactly
// those cycles. The storage returns mem_rdata one cycle after read_en. The
// data is registered at the end of that cycle and shown on rdata with rvalid
// high during the following cycle, so rinc-to-rvalid latency is 2 cycles. A
// request made while the FIFO is empty is dropped and gives a one-cycle
// runderflow pulse.
//
// Build option: define FIFO_RD_SYNC_EN when rq2_waddr carries the raw
// write-domain Gray pointer. Two reset-0 flops then synchronize it inside this
// block. Without the macro, rq2_waddr is used as-is. The port list is the
// same in both builds.
//
// Ports:
//   clk        in   clock, all state updates on the rising edge
//   rst        in   synchronous active-high reset
//   rinc       in   read request from the consumer
//   rq2_waddr  in   Gray-coded write pointer (read domain)
//   mem_rdata  in   storage read data, valid one cycle after read_en
//   read_en    out  storage read strobe (combinational, = accepted read)
//   raddr      out  binary read address (registered)
//   raddr_gray out  Gray read pointer to write side (registered)
//   rempty     out  FIFO empty (registered)
//   rcount     out  occupancy (registered)
//   rdata      out  read data (registered, holds when rvalid=0)
//   rvalid     out  one-cycle pulse per accepted read
//   runderflow out  one-cycle pulse on a read request while empty
// ---------------------------------------------------------------------------
module fifo_read_logic #(
    parameter int DEPTH  = 3,
    parameter int PTR_SZ = 2,
    parameter int WIDTH  = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              rinc,
    input  logic [PTR_SZ-1:0] rq2_waddr,
    input  logic [WIDTH-1:0]  mem_rdata,
    output logic              read_en,
    output logic [PTR_SZ-1:0] raddr,
    output logic [PTR_SZ-1:0] raddr_gray,
    output logic              rempty,
    output logic [PTR_SZ-1:0] rcount,
    output logic [WIDTH-1:0]  rdata,
    output logic              rvalid,
    output logic              runderflow
);

    typedef enum logic [1:0] {
        ST_INIT  = 2'd0,
        ST_EMPTY = 2'd1,
        ST_AVAIL = 2'd2
    } state_t;

    localparam logic [PTR_SZ-1:0] LAST_ADDR = PTR_SZ'(DEPTH - 1);
    localparam logic [PTR_SZ:0]   DEPTH_X   = (PTR_SZ + 1)'(DEPTH);

    state_t            state_q;
    logic [PTR_SZ-1:0] raddr_q;
    logic [PTR_SZ-1:0] raddr_gray_q;
    logic              rempty_q;
    logic [PTR_SZ-1:0] rcount_q;
    logic [WIDTH-1:0]  rdata_q;
    logic              rvalid_q;
    logic              runderflow_q;
    logic              rd_pend_q;    // accept seen last cycle; mem_rdata valid now

    logic [PTR_SZ-1:0] wgray;
    logic [PTR_SZ-1:0] wbin;
    logic              accept;
    logic [PTR_SZ-1:0] raddr_d;
    logic              rempty_d;
    logic [PTR_SZ:0]   count_sum;
    logic [PTR_SZ-1:0] rcount_d;

`ifdef FIFO_RD_SYNC_EN
    logic [PTR_SZ-1:0] wsync1_q;
    logic [PTR_SZ-1:0] wsync2_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            wsync1_q <= '0;
            wsync2_q <= '0;
        end else begin
            wsync1_q <= rq2_waddr;
            wsync2_q <= wsync1_q;
        end
    end

    assign wgray = wsync2_q;
`else
    assign wgray = rq2_waddr;
`endif

    always_comb begin
        // Gray to binary: bit i is the XOR of bits i and above.
        wbin = '0;
        for (int i = 0; i < PTR_SZ; i++) begin
            wbin[i] = ^(wgray >> i);
        end

        accept = rinc & ~rempty_q & (state_q != ST_INIT) & ~rst;

        // Wrap at DEPTH-1, not at the natural power-of-two boundary.
        raddr_d = raddr_q;
        if (accept) begin
            raddr_d = (raddr_q == LAST_ADDR) ? '0 : raddr_q + 1'b1;
        end

        rempty_d = (raddr_d == wbin);

        // Both operands are below DEPTH, so the sum is below 2*DEPTH and
        // one conditional subtract does the modulo.
        count_sum = {1'b0, wbin} + DEPTH_X - {1'b0, raddr_d};
        if (count_sum >= DEPTH_X) begin
            count_sum = count_sum - DEPTH_X;
        end
        rcount_d = count_sum[PTR_SZ-1:0];
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= ST_INIT;
            raddr_q      <= '0;
            raddr_gray_q <= '0;
            rempty_q     <= 1'b1;
            rcount_q     <= '0;
            rdata_q      <= '0;
            rvalid_q     <= 1'b0;
            runderflow_q <= 1'b0;
            rd_pend_q    <= 1'b0;
        end else begin
            // The FSM and rempty follow the same next-empty test. INIT holds
            // off reads for one cycle while the pointer compare settles.
            case (state_q)
                ST_INIT:  state_q <= rempty_d ? ST_EMPTY : ST_AVAIL;
                ST_EMPTY: state_q <= rempty_d ? ST_EMPTY : ST_AVAIL;
                ST_AVAIL: state_q <= rempty_d ? ST_EMPTY : ST_AVAIL;
                default:  state_q <= ST_INIT;
            endcase

            raddr_q      <= raddr_d;
            raddr_gray_q <= raddr_d ^ (raddr_d >> 1);
            rempty_q     <= rempty_d;
            rcount_q     <= rcount_d;
            runderflow_q <= rinc & rempty_q & (state_q != ST_INIT);

            // Two-stage capture: the accept marks the next cycle's mem_rdata
            // as wanted. The data is captured then and flagged for one cycle.
            rd_pend_q <= accept;
            rvalid_q  <= rd_pend_q;
            if (rd_pend_q) begin
                rdata_q <= mem_rdata;
            end
        end
    end

    assign read_en    = accept;
    assign raddr      = raddr_q;
    assign raddr_gray = raddr_gray_q;
    assign rempty     = rempty_q;
    assign rcount     = rcount_q;
    assign rdata      = rdata_q;
    assign rvalid     = rvalid_q;
    assign runderflow = runderflow_q;

endmodule

// File: tb/tb_fifo_read_logic.sv
// Directed bench for fifo_read_logic (DEPTH=3, PTR_SZ=2, WIDTH=8).
// Inputs change 1 time unit after a rising edge. Registered outputs are
// checked at that point. The combinational read_en is checked one unit after
// the inputs are applied.
module tb_fifo_read_logic;

  localparam int DEPTH  = 3;
  localparam int PTR_SZ = 2;
  localparam int WIDTH  = 8;

`ifdef FIFO_RD_SYNC_EN
  localparam int SYNC_LAT = 2;
`else
  localparam int SYNC_LAT = 0;
`endif

  logic              clk;
  logic              rst;
  logic              rinc;
  logic [PTR_SZ-1:0] rq2_waddr;
  logic [WIDTH-1:0]  mem_rdata;
  logic              read_en;
  logic [PTR_SZ-1:0] raddr;
  logic [PTR_SZ-1:0] raddr_gray;
  logic              rempty;
  logic [PTR_SZ-1:0] rcount;
  logic [WIDTH-1:0]  rdata;
  logic              rvalid;
  logic              runderflow;

  int n_checks;
  int n_fail;

  fifo_read_logic #(
    .DEPTH  (DEPTH),
    .PTR_SZ (PTR_SZ),
    .WIDTH  (WIDTH)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .rinc       (rinc),
    .rq2_waddr  (rq2_waddr),
    .mem_rdata  (mem_rdata),
    .read_en    (read_en),
    .raddr      (raddr),
    .raddr_gray (raddr_gray),
    .rempty     (rempty),
    .rcount     (rcount),
    .rdata      (rdata),
    .rvalid     (rvalid),
    .runderflow (runderflow)
  );

  // clock
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  initial begin
    n_checks  = 0;
    n_fail    = 0;
    rst       = 1'b1;
    rinc      = 1'b1;
    rq2_waddr = 2'b00;
    mem_rdata = 8'h00;

    // Reset, with rinc high to show read_en stays low.
    tick();
    tick();
    settle();
    check("rst_read_en",    read_en,    0);
    check("rst_raddr",      raddr,      0);
    check("rst_raddr_gray", raddr_gray, 0);
    check("rst_rempty",     rempty,     1);
    check("rst_rcount",     rcount,     0);
    check("rst_rvalid",     rvalid,     0);
    check("rst_runderflow", runderflow, 0);
    check("rst_rdata",      rdata,      0);

    // INIT cycle: rinc high while empty must not raise underflow.
    rst       = 1'b0;
    rq2_waddr = 2'b01;
    settle();
    check("init_read_en", read_en, 0);
    tick();
    rinc = 1'b0;
    check("init_no_underflow", runderflow, 0);
    check("init_raddr",        raddr,      0);
    repeat (SYNC_LAT) tick();
    check("one_rempty", rempty, 0);
    check("one_rcount", rcount, 1);

    // Single read of 8'hA5.
    rinc = 1'b1;
    settle();
    check("single_read_en", read_en, 1);
    check("single_raddr0",  raddr,   0);
    tick();
    rinc      = 1'b0;
    mem_rdata = 8'hA5;
    check("single_raddr1",  raddr,      1);
    check("single_gray",    raddr_gray, 2'b01);
    check("single_rempty",  rempty,     1);
    check("single_rcount",  rcount,     0);
    check("single_rvalid0", rvalid,     0);
    tick();
    mem_rdata = 8'h3C;
    check("single_rvalid1", rvalid, 1);
    check("single_rdata",   rdata,  8'hA5);
    tick();
    check("single_rvalid_end", rvalid, 0);
    check("single_rdata_hold", rdata,  8'hA5);

    // Wrap: write pointer moves to 0 (two words), read through DEPTH-1 -> 0.
    rq2_waddr = 2'b00;
    tick();
    repeat (SYNC_LAT) tick();
    check("wrap_rcount2", rcount, 2);
    check("wrap_rempty0", rempty, 0);
    rinc = 1'b1;
    tick();
    check("wrap_raddr2",  raddr,      2);
    check("wrap_gray2",   raddr_gray, 2'b11);
    check("wrap_rcount1", rcount,     1);
    tick();
    rinc = 1'b0;
    check("wrap_raddr0",  raddr,      0);
    check("wrap_gray0",   raddr_gray, 2'b00);
    check("wrap_rempty1", rempty,     1);
    check("wrap_rcount0", rcount,     0);
    tick();
    tick();

    // Underflow.
    rinc = 1'b1;
    settle();
    check("uf_read_en", read_en, 0);
    tick();
    rinc = 1'b0;
    check("uf_pulse",  runderflow, 1);
    check("uf_raddr",  raddr,      0);
    check("uf_rvalid", rvalid,     0);
    check("uf_rempty", rempty,     1);
    tick();
    check("uf_pulse_end", runderflow, 0);

    // Back-to-back: write pointer Gray 11 = binary 2.
    rq2_waddr = 2'b11;
    tick();
    repeat (SYNC_LAT) tick();
    check("b2b_rcount", rcount, 2);
    check("b2b_rempty", rempty, 0);
    rinc = 1'b1;
    settle();
    check("b2b_en0", read_en, 1);
    tick();
    mem_rdata = 8'h11;
    settle();
    check("b2b_en1",    read_en, 1);
    check("b2b_raddr1", raddr,   1);
    tick();
    mem_rdata = 8'h22;
    check("b2b_raddr2",  raddr,  2);
    check("b2b_rempty1", rempty, 1);
    check("b2b_rvalid1", rvalid, 1);
    check("b2b_rdata1",  rdata,  8'h11);
    settle();
    check("b2b_en2", read_en, 0);
    tick();
    rinc      = 1'b0;
    mem_rdata = 8'h00;
    check("b2b_underflow", runderflow, 1);
    check("b2b_rvalid2",   rvalid,     1);
    check("b2b_rdata2",    rdata,      8'h22);
    check("b2b_raddr_hold", raddr,     2);
    tick();
    check("b2b_rvalid_end", rvalid,     0);
    check("b2b_uf_end",     runderflow, 0);

    // Reset while a read is in flight.
    rq2_waddr = 2'b00;
    tick();
    repeat (SYNC_LAT) tick();
    check("mid_rcount", rcount, 1);
    check("mid_rempty", rempty, 0);
    rinc = 1'b1;
    settle();
    check("mid_read_en", read_en, 1);
    tick();
    rinc      = 1'b0;
    rst       = 1'b1;
    mem_rdata = 8'h77;
    rq2_waddr = 2'b01;
    tick();
    check("mid_rvalid", rvalid, 0);
    check("mid_raddr",  raddr,  0);
    check("mid_rempty", rempty, 1);
    check("mid_rcount", rcount, 0);
    check("mid_rdata",  rdata,  0);
    rst  = 1'b0;
    rinc = 1'b1;
    tick();
    rinc = 1'b0;
    check("mid_init_no_uf", runderflow, 0);
    check("mid_rvalid_after", rvalid,   0);
    repeat (SYNC_LAT) tick();
    check("mid_rempty_after", rempty, 0);
    check("mid_rcount_after", rcount, 1);
    tick();
    check("mid_rvalid_late", rvalid, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
